// File: rtl/bus_grant_ctrl_if.sv
// Bus-grant handshake bundle: per-source requests in, registered grants and
// status out. The arbiter takes the master view, the bus sources take the slave view.
interface bus_grant_ctrl_if;
   logic [3:0] req;
   logic [3:0] grant;
   logic [1:0] owner;
   logic       busy;
   logic       timeout;

   modport master (
      input  req,
      output grant,
      output owner,
      output busy,
      output timeout
   );

   modport slave (
      output req,
      input  grant,
      input  owner,
      input  busy,
      input  timeout
   );
endinterface : bus_grant_ctrl_if

// File: rtl/bus_grant_ctrl.sv
// Round-robin arbiter for the shared 8-bit internal bus (reg A, reg B, ALU,
// memory data). It produces registered one-hot AND-gate enables.
// A dead turnaround cycle separates owners, and the hold time is bounded by
// a forced revoke after MAX_HOLD consecutive cycles.
module bus_grant_ctrl #(
   parameter int MAX_HOLD = 8,
   parameter int HOLD_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   bus_grant_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_TURN  = 2'd2
   } state_t;

   // Last counter value before the owner must give the bus up.
   localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

   state_t            state_q, state_d;
   logic [1:0]        ptr_q,   ptr_d;
   logic [HOLD_W-1:0] hold_q,  hold_d;
   logic [3:0]        grant_q, grant_d;
   logic [1:0]        owner_q, owner_d;
   logic              busy_q,  busy_d;
   logic              timeout_q, timeout_d;
   logic [1:0]        win_s;

   // Scan requests upward from the pointer (mod 4) and return the first set
   // index. An all-zero request vector returns the pointer itself, and the
   // caller ignores it.
   function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
      logic [1:0] idx;
      logic [1:0] win;
      logic       found;
      win   = p;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = p + 2'(k);
         if (!found && r[idx]) begin
            win   = idx;
            found = 1'b1;
         end else begin
            win   = win;
         end
      end
      return win;
   endfunction

   assign win_s = rr_pick(bus.req, ptr_q);

   // Next-state and next-output logic. Outputs are computed one cycle ahead so
   // that the bus enables come straight from flops.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      hold_d    = hold_q;
      grant_d   = grant_q;
      owner_d   = owner_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE, ST_TURN: begin
            if (bus.req != 4'b0000) begin
               state_d = ST_GRANT;
               grant_d = 4'b0001 << win_s;
               owner_d = win_s;
               hold_d  = {HOLD_W{1'b0}};
            end else begin
               state_d = ST_IDLE;
               grant_d = 4'b0000;
               owner_d = 2'd0;
               hold_d  = {HOLD_W{1'b0}};
            end
         end
         ST_GRANT: begin
            // A release wins over the limit, so timeout only flags a true revoke.
            if (!bus.req[owner_q] || (hold_q == HOLD_LIMIT)) begin
               state_d   = ST_TURN;
               grant_d   = 4'b0000;
               owner_d   = 2'd0;
               hold_d    = {HOLD_W{1'b0}};
               ptr_d     = owner_q + 2'd1;
               timeout_d = bus.req[owner_q];
            end else begin
               hold_d = hold_q + HOLD_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            ptr_d   = 2'd0;
            hold_d  = {HOLD_W{1'b0}};
            grant_d = 4'b0000;
            owner_d = 2'd0;
         end
      endcase
      busy_d = (grant_d != 4'b0000);
   end

   // State and output registers. Reset clears the enables without waiting for an edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ptr_q     <= 2'd0;
         hold_q    <= {HOLD_W{1'b0}};
         grant_q   <= 4'b0000;
         owner_q   <= 2'd0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         hold_q    <= hold_d;
         grant_q   <= grant_d;
         owner_q   <= owner_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign bus.grant   = grant_q;
   assign bus.owner   = owner_q;
   assign bus.busy    = busy_q;
   assign bus.timeout = timeout_q;

endmodule : bus_grant_ctrl

// File: tb/tb_bus_grant_ctrl.sv
// Self-checking bench for bus_grant_ctrl: a vector table, hand-written
// multi-cycle sequences, and a random phase checked against an owner/hold-count model.
module tb_bus_grant_ctrl;

   localparam int MAX_HOLD = 8;

   typedef struct {
      logic [3:0] req;
      logic [3:0] grant;
      logic [1:0] owner;
      logic       timeout;
   } vec_t;

   logic clk;
   logic rst;
   int   n_tests;
   int   n_fail;
   bit   use_model;
   logic [3:0] prev_grant;
   logic       prev_timeout;

   // Behavioural model: current owner (-1 = bus free), visible cycles held so far, and pointer.
   int   m_owner;
   int   m_held;
   int   m_ptr;
   logic m_timeout;

   vec_t tbl[$];

   bus_grant_ctrl_if bus_if ();

   bus_grant_ctrl #(.MAX_HOLD(MAX_HOLD), .HOLD_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner   = -1;
      m_held    = 0;
      m_ptr     = 0;
      m_timeout = 1'b0;
   endtask

   // One rising edge of the model. While the bus is free, any request is served.
   // An owner keeps the bus until it drops its request or has held it MAX_HOLD cycles.
   task automatic model_edge(input logic [3:0] r);
      int idx;
      m_timeout = 1'b0;
      if (m_owner >= 0) begin
         if (!r[m_owner]) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
         end else if (m_held == MAX_HOLD) begin
            m_ptr     = (m_owner + 1) % 4;
            m_owner   = -1;
            m_timeout = 1'b1;
         end else begin
            m_held++;
         end
      end else if (r != 4'b0000) begin
         for (int k = 0; k < 4; k++) begin
            idx = (m_ptr + k) % 4;
            if (m_owner < 0 && r[idx]) m_owner = idx;
         end
         m_held = 1;
      end
   endtask

   task automatic check_invariants();
      check("onehot0", 32'($countones(bus_if.grant) <= 1), 32'd1);
      check("busy_vs_grant", 32'(bus_if.busy), 32'(bus_if.grant != 4'b0000));
      if (bus_if.busy)
         check("owner_vs_grant", 32'(bus_if.grant), 32'(4'b0001 << bus_if.owner));
      else
         check("owner_idle", 32'(bus_if.owner), 32'd0);
      check("no_direct_handover",
            32'(prev_grant != 4'b0000 && bus_if.grant != 4'b0000 && bus_if.grant != prev_grant),
            32'd0);
      check("timeout_not_back_to_back", 32'(prev_timeout && bus_if.timeout), 32'd0);
      prev_grant   = bus_if.grant;
      prev_timeout = bus_if.timeout;
   endtask

   task automatic step(input logic [3:0] r);
      logic [3:0] exp_g;
      bus_if.req = r;
      @(posedge clk);
      model_edge(r);
      #1;
      check_invariants();
      if (use_model) begin
         exp_g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
         check("model_grant", 32'(bus_if.grant), 32'(exp_g));
         check("model_owner", 32'(bus_if.owner), 32'((m_owner >= 0) ? m_owner : 0));
         check("model_busy", 32'(bus_if.busy), 32'(m_owner >= 0));
         check("model_timeout", 32'(bus_if.timeout), 32'(m_timeout));
      end
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus_if.req = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      check("rst_grant", 32'(bus_if.grant), 32'd0);
      check("rst_owner", 32'(bus_if.owner), 32'd0);
      check("rst_busy", 32'(bus_if.busy), 32'd0);
      check("rst_timeout", 32'(bus_if.timeout), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      prev_grant   = 4'b0000;
      prev_timeout = 1'b0;
   endtask

   initial begin
      logic [3:0] cur;
      int s;
      int pos;
      n_tests    = 0;
      n_fail     = 0;
      use_model  = 1'b0;
      rst        = 1'b1;
      bus_if.req = 4'b0000;
      model_reset();

      // Directed table, starting from reset with ptr = 0.
      tbl.push_back('{req: 4'b0100, grant: 4'b0100, owner: 2'd2, timeout: 1'b0});
      tbl.push_back('{req: 4'b0100, grant: 4'b0100, owner: 2'd2, timeout: 1'b0});
      tbl.push_back('{req: 4'b0100, grant: 4'b0100, owner: 2'd2, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b1001, grant: 4'b1000, owner: 2'd3, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0001, grant: 4'b0001, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0110, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0110, grant: 4'b0010, owner: 2'd1, timeout: 1'b0});
      tbl.push_back('{req: 4'b0110, grant: 4'b0010, owner: 2'd1, timeout: 1'b0});
      tbl.push_back('{req: 4'b0100, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0100, grant: 4'b0100, owner: 2'd2, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{req: 4'b0010, grant: 4'b0010, owner: 2'd1, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0110, grant: 4'b0100, owner: 2'd2, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});
      tbl.push_back('{req: 4'b0000, grant: 4'b0000, owner: 2'd0, timeout: 1'b0});

      do_reset();
      for (int i = 0; i < tbl.size(); i++) begin
         step(tbl[i].req);
         check($sformatf("tbl%0d_grant", i), 32'(bus_if.grant), 32'(tbl[i].grant));
         check($sformatf("tbl%0d_owner", i), 32'(bus_if.owner), 32'(tbl[i].owner));
         check($sformatf("tbl%0d_busy", i), 32'(bus_if.busy), 32'(tbl[i].grant != 4'b0000));
         check($sformatf("tbl%0d_timeout", i), 32'(bus_if.timeout), 32'(tbl[i].timeout));
      end

      // Reset in the middle of a grant must clear the outputs without waiting for a clock edge.
      do_reset();
      step(4'b0001);
      check("midrst_pre_grant", 32'(bus_if.grant), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check("midrst_grant", 32'(bus_if.grant), 32'd0);
      check("midrst_busy", 32'(bus_if.busy), 32'd0);
      check("midrst_owner", 32'(bus_if.owner), 32'd0);
      model_reset();
      prev_grant   = 4'b0000;
      prev_timeout = 1'b0;
      @(negedge clk);
      bus_if.req = 4'b0010;
      rst        = 1'b0;
      step(4'b0010);
      check("midrst_after_grant", 32'(bus_if.grant), 32'h2);
      check("midrst_after_owner", 32'(bus_if.owner), 32'd1);

      // All four sources requesting, each held to timeout: a 9-cycle rotation per source.
      do_reset();
      for (int k = 0; k < 37; k++) begin
         step(4'b1111);
         s   = k / 9;
         pos = k % 9;
         check($sformatf("rr%0d_grant", k), 32'(bus_if.grant),
               (pos < 8) ? 32'(4'b0001 << (s % 4)) : 32'd0);
         check($sformatf("rr%0d_timeout", k), 32'(bus_if.timeout), 32'(pos == 8));
      end

      // A lone requester is revoked at the limit and granted again after one dead cycle.
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step(4'b0001);
         pos = k % 9;
         check($sformatf("lone%0d_grant", k), 32'(bus_if.grant), (pos < 8) ? 32'h1 : 32'h0);
         check($sformatf("lone%0d_timeout", k), 32'(bus_if.timeout), 32'(pos == 8));
      end

      // Random phase: slowly changing requests so long holds and timeouts occur.
      do_reset();
      use_model = 1'b1;
      cur = 4'($urandom_range(0, 15));
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) cur = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 599) == 0) do_reset();
         step(cur);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_bus_grant_ctrl
